// File: rtl/ext_master_arbiter.sv
// ext_master_arbiter: shares one external-bus master port between two
// requesters with round-robin arbitration. A granted transaction is held on
// the master port until the bridge acknowledges it. The completion is then
// returned to the owner as a one-cycle acknowledge pulse.
//
// Handshake: a requester raises read or write (level) with address, byte
// enables and write data stable, and holds them until its acknowledge pulse.
// Write wins if both are high. The master side drives read/write with
// constant m_* fields until a one-cycle m_acknowledge arrives.
//
// Optional build macro ARB_TIMEOUT_EN adds an acknowledge watchdog that
// aborts a stalled transaction after TIMEOUT_CYCLES busy cycles. The aborted
// transaction returns 32'hDEADBEEF and sets a sticky per-requester error.
module ext_master_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic [DATA_W/8-1:0] r0_byte_enable,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_write_data,
  output logic                r0_acknowledge,
  output logic [DATA_W-1:0]   r0_read_data,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic [DATA_W/8-1:0] r1_byte_enable,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_write_data,
  output logic                r1_acknowledge,
  output logic [DATA_W-1:0]   r1_read_data,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byte_enable,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_write_data,
  input  logic                m_acknowledge,
  input  logic [DATA_W-1:0]   m_read_data,
  output logic [1:0]          timeout_err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant;  // requester served most recently
  logic   r_grant;       // owner of the transaction in flight

  logic              w_r0_req;
  logic              w_r1_req;
  logic              w_any_req;
  logic              w_pick;
  logic [ADDR_W-1:0] w_sel_address;
  logic [BE_W-1:0]   w_sel_byte_enable;
  logic [DATA_W-1:0] w_sel_write_data;
  logic              w_sel_write;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  // Round-robin pick and mux of the winning requester's fields
  always_comb begin
    w_r0_req          = r0_read | r0_write;
    w_r1_req          = r1_read | r1_write;
    w_any_req         = w_r0_req | w_r1_req;
    w_pick            = (w_r0_req && w_r1_req) ? ~r_last_grant : w_r1_req;
    w_sel_address     = w_pick ? r1_address     : r0_address;
    w_sel_byte_enable = w_pick ? r1_byte_enable : r0_byte_enable;
    w_sel_write_data  = w_pick ? r1_write_data  : r0_write_data;
    w_sel_write       = w_pick ? r1_write       : r0_write;
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_grant        <= 1'b0;
      m_address      <= '0;
      m_byte_enable  <= '0;
      m_read         <= 1'b0;
      m_write        <= 1'b0;
      m_write_data   <= '0;
      r0_acknowledge <= 1'b0;
      r1_acknowledge <= 1'b0;
      r0_read_data   <= '0;
      r1_read_data   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt          <= '0;
      timeout_err    <= 2'b00;
`endif
    end else begin
      r0_acknowledge <= 1'b0;
      r1_acknowledge <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            m_address     <= w_sel_address;
            m_byte_enable <= w_sel_byte_enable;
            m_write_data  <= w_sel_write_data;
            m_write       <= w_sel_write;
            m_read        <= ~w_sel_write;
            r_grant       <= w_pick;
            r_state       <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt         <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (m_acknowledge) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            r_last_grant <= r_grant;
            r_state      <= S_DONE;
            if (r_grant) begin
              r1_acknowledge <= 1'b1;
              r1_read_data   <= m_write ? '0 : m_read_data;
            end else begin
              r0_acknowledge <= 1'b1;
              r0_read_data   <= m_write ? '0 : m_read_data;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            r_last_grant <= r_grant;
            r_state      <= S_DONE;
            if (r_grant) begin
              r1_acknowledge <= 1'b1;
              r1_read_data   <= DATA_W'(32'hDEADBEEF);
              timeout_err[1] <= 1'b1;
            end else begin
              r0_acknowledge <= 1'b1;
              r0_read_data   <= DATA_W'(32'hDEADBEEF);
              timeout_err[0] <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE: begin
          // Acknowledge drops via the default; requester gets a cycle to
          // release its strobe before the next arbitration.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout_err = 2'b00;
`endif

endmodule

// File: tb/tb_ext_master_arbiter.sv
// Directed testbench for ext_master_arbiter: single read, tie after reset,
// round-robin fairness, read+write collision, reset during a transaction and,
// when built with ARB_TIMEOUT_EN, the acknowledge watchdog.
module tb_ext_master_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [AW-1:0] r0_address, r1_address, m_address;
  logic [BW-1:0] r0_byte_enable, r1_byte_enable, m_byte_enable;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [DW-1:0] r0_write_data, r1_write_data, m_write_data;
  logic          r0_acknowledge, r1_acknowledge;
  logic [DW-1:0] r0_read_data, r1_read_data;
  logic          m_read, m_write, m_acknowledge;
  logic [DW-1:0] m_read_data;
  logic [1:0]    timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  ext_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_byte_enable(r0_byte_enable),
    .r0_read(r0_read), .r0_write(r0_write), .r0_write_data(r0_write_data),
    .r0_acknowledge(r0_acknowledge), .r0_read_data(r0_read_data),
    .r1_address(r1_address), .r1_byte_enable(r1_byte_enable),
    .r1_read(r1_read), .r1_write(r1_write), .r1_write_data(r1_write_data),
    .r1_acknowledge(r1_acknowledge), .r1_read_data(r1_read_data),
    .m_address(m_address), .m_byte_enable(m_byte_enable),
    .m_read(m_read), .m_write(m_write), .m_write_data(m_write_data),
    .m_acknowledge(m_acknowledge), .m_read_data(m_read_data),
    .timeout_err(timeout_err)
  );

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    r0_address = '0; r0_byte_enable = '0; r0_read = 0; r0_write = 0; r0_write_data = '0;
    r1_address = '0; r1_byte_enable = '0; r1_read = 0; r1_write = 0; r1_write_data = '0;
    m_acknowledge = 0; m_read_data = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Bridge model: waits for a strobe, records the m_* fields, keeps the
  // strobe for lat cycles (checking the fields stay put) then acks once.
  // Returns at the negedge where the owner's acknowledge should be high.
  task automatic serve(input int lat, input logic [DW-1:0] rdata,
                       output logic [AW-1:0] addr, output logic rd,
                       output logic wr, output logic [DW-1:0] wdata,
                       output logic [BW-1:0] be, output int hold);
    hold = 0;
    addr = '0; rd = 0; wr = 0; wdata = '0; be = '0;
    for (int i = 0; i < 20 && !(m_read || m_write); i++) tick();
    tests_run++;
    if (!(m_read || m_write)) begin
      tests_failed++;
      $display("FAIL serve_wait: no strobe within 20 cycles (m_read=%b m_write=%b)", m_read, m_write);
      return;
    end
    addr = m_address; rd = m_read; wr = m_write; wdata = m_write_data; be = m_byte_enable;
    hold = 1;
    for (int i = 1; i < lat; i++) begin
      tick();
      if (m_read || m_write) hold++;
      tests_run++;
      if ({m_address, m_read, m_write, m_write_data, m_byte_enable} !== {addr, rd, wr, wdata, be}) begin
        tests_failed++;
        $display("FAIL busy_hold: m_* changed while busy, addr %h vs %h", m_address, addr);
      end
    end
    m_read_data   = rdata;
    m_acknowledge = 1'b1;
    tick();
    m_acknowledge = 1'b0;
    m_read_data   = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({m_address, m_byte_enable, m_read, m_write, m_write_data, r0_acknowledge, r1_acknowledge,
         r0_read_data, r1_read_data, timeout_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got m_addr=%h m_rd=%b m_wr=%b ack=%b%b, required all 0",
               m_address, m_read, m_write, r0_acknowledge, r1_acknowledge);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r0_address = 12'h010; r0_byte_enable = 4'hF; r0_read = 1;
    serve(3, 32'h12345678, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({a, rd, wr} !== {12'h010, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_fields: addr=%h rd=%b wr=%b, required 010 1 0", a, rd, wr);
    end
    tests_run++;
    if (hold !== 3) begin
      tests_failed++;
      $display("FAIL single_hold: m_read high %0d cycles, required 3", hold);
    end
    tests_run++;
    if ({m_read, r0_acknowledge, r0_read_data} !== {1'b0, 1'b1, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL single_ack: m_read=%b ack=%b data=%h, required 0 1 12345678",
               m_read, r0_acknowledge, r0_read_data);
    end
    tests_run++;
    if ({r1_acknowledge, r1_read_data} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL single_r1_quiet: r1 ack=%b data=%h, required 0 0", r1_acknowledge, r1_read_data);
    end
    r0_read = 0;
    tick();
    tests_run++;
    if (r0_acknowledge !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse: ack=%b second cycle, required 0", r0_acknowledge);
    end
  endtask

  task automatic test_tie_writes;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r0_address = 12'h020; r0_write_data = 32'hAAAA0000; r0_byte_enable = 4'hF; r0_write = 1;
    r1_address = 12'h030; r1_write_data = 32'h5555FFFF; r1_byte_enable = 4'hC; r1_write = 1;
    serve(2, 32'h11111111, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({a, wr, rd, wd} !== {12'h020, 1'b1, 1'b0, 32'hAAAA0000}) begin
      tests_failed++;
      $display("FAIL tie_first: addr=%h wr=%b wdata=%h, required 020 1 AAAA0000", a, wr, wd);
    end
    tests_run++;
    if ({r0_acknowledge, r1_acknowledge, r0_read_data} !== {1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL tie_first_ack: ack=%b%b r0_data=%h, required 1 0 0",
               r0_acknowledge, r1_acknowledge, r0_read_data);
    end
    r0_write = 0;
    serve(1, 32'h22222222, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({a, wr, wd, be} !== {12'h030, 1'b1, 32'h5555FFFF, 4'hC}) begin
      tests_failed++;
      $display("FAIL tie_second: addr=%h wr=%b wdata=%h be=%h, required 030 1 5555FFFF C", a, wr, wd, be);
    end
    tests_run++;
    if ({r1_acknowledge, r0_acknowledge} !== 2'b10) begin
      tests_failed++;
      $display("FAIL tie_second_ack: r1=%b r0=%b, required 1 0", r1_acknowledge, r0_acknowledge);
    end
    r1_write = 0;
    tick();
  endtask

  task automatic test_fairness;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    logic exp_q[$];
    logic [DW-1:0] last0, last1, dat;
    logic exp_g;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    last0 = '0; last1 = '0;
    r0_address = 12'h100; r0_read = 1;
    r1_address = 12'h200; r1_read = 1;
    for (int k = 0; k < 4; k++) begin
      dat = 32'hF00D0000 + DW'(k);
      exp_g = exp_q.pop_front();
      serve(1 + k, dat, a, rd, wr, wd, be, hold);
      tests_run++;
      if (a !== (exp_g ? 12'h200 : 12'h100)) begin
        tests_failed++;
        $display("FAIL fair_grant_%0d: addr=%h, required requester %0d", k, a, exp_g);
      end
      if (exp_g) last1 = dat; else last0 = dat;
      tests_run++;
      if ({r0_acknowledge, r1_acknowledge, r0_read_data, r1_read_data} !==
          {~exp_g, exp_g, last0, last1}) begin
        tests_failed++;
        $display("FAIL fair_ack_%0d: ack=%b%b data0=%h data1=%h, required %b%b %h %h", k,
                 r0_acknowledge, r1_acknowledge, r0_read_data, r1_read_data, ~exp_g, exp_g, last0, last1);
      end
    end
    r0_read = 0; r1_read = 0;
    repeat (2) tick();
  endtask

  task automatic test_read_write_r1;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r1_address = 12'h040; r1_read = 1;
    serve(1, 32'h0BADF00D, a, rd, wr, wd, be, hold);
    tests_run++;
    if (r1_read_data !== 32'h0BADF00D) begin
      tests_failed++;
      $display("FAIL rw_prior_read: data=%h, required 0BADF00D", r1_read_data);
    end
    r1_address = 12'h050; r1_write = 1; r1_byte_enable = 4'b0011; r1_write_data = 32'h13579BDF;
    serve(2, 32'hCAFEF00D, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({a, wr, rd, be, wd} !== {12'h050, 1'b1, 1'b0, 4'b0011, 32'h13579BDF}) begin
      tests_failed++;
      $display("FAIL rw_fields: addr=%h wr=%b rd=%b be=%b wdata=%h, required 050 1 0 0011 13579BDF",
               a, wr, rd, be, wd);
    end
    tests_run++;
    if ({r1_acknowledge, r1_read_data, r0_acknowledge} !== {1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rw_ack: ack=%b data=%h r0_ack=%b, required 1 0 0",
               r1_acknowledge, r1_read_data, r0_acknowledge);
    end
    r1_read = 0; r1_write = 0;
    tick();
  endtask

  task automatic test_reset_busy;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r0_address = 12'h060; r0_read = 1;
    for (int i = 0; i < 20 && !m_read; i++) tick();
    tests_run++;
    if (m_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rb_start: m_read=%b, required 1", m_read);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({m_read, m_write, m_address, r0_acknowledge} !== '0) begin
      tests_failed++;
      $display("FAIL rb_async: m_read=%b m_write=%b addr=%h ack=%b without edge, required 0",
               m_read, m_write, m_address, r0_acknowledge);
    end
    r0_read = 0;
    tick();
    reset = 1'b0;
    tick();
    m_acknowledge = 1'b1; m_read_data = 32'h99999999;
    tick();
    m_acknowledge = 1'b0; m_read_data = '0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({r0_acknowledge, r1_acknowledge, m_read, m_write, r0_read_data} !== '0) begin
        tests_failed++;
        $display("FAIL rb_stray_%0d: ack=%b%b m_rd=%b m_wr=%b data=%h, required 0", i,
                 r0_acknowledge, r1_acknowledge, m_read, m_write, r0_read_data);
      end
      tick();
    end
    r0_address = 12'h070; r0_read = 1;
    r1_address = 12'h080; r1_read = 1;
    serve(1, 32'h00C0FFEE, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({a, r0_acknowledge, r0_read_data} !== {12'h070, 1'b1, 32'h00C0FFEE}) begin
      tests_failed++;
      $display("FAIL rb_tie: addr=%h ack=%b data=%h, required 070 1 00C0FFEE", a, r0_acknowledge, r0_read_data);
    end
    r0_read = 0; r1_read = 0;
    repeat (4) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r1_address = 12'h090; r1_read = 1;
    for (int i = 0; i < 20 && !m_read; i++) tick();
    hold = 0;
    for (int i = 0; i < 40 && m_read; i++) begin
      hold++;
      tick();
    end
    tests_run++;
    if (hold !== TO + 1) begin
      tests_failed++;
      $display("FAIL to_hold: strobe high %0d cycles, required %0d", hold, TO + 1);
    end
    tests_run++;
    if ({m_read, r1_acknowledge, r1_read_data, timeout_err} !== {1'b0, 1'b1, 32'hDEADBEEF, 2'b10}) begin
      tests_failed++;
      $display("FAIL to_abort: m_read=%b ack=%b data=%h err=%b, required 0 1 DEADBEEF 10",
               m_read, r1_acknowledge, r1_read_data, timeout_err);
    end
    r1_read = 0;
    tick();
    r0_address = 12'h0A0; r0_read = 1;
    serve(2, 32'h76543210, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({r0_acknowledge, r0_read_data, timeout_err} !== {1'b1, 32'h76543210, 2'b10}) begin
      tests_failed++;
      $display("FAIL to_sticky: ack=%b data=%h err=%b, required 1 76543210 10",
               r0_acknowledge, r0_read_data, timeout_err);
    end
    r0_read = 0;
    tick();
  endtask
`else
  task automatic test_no_timeout;
    logic [AW-1:0] a; logic rd, wr; logic [DW-1:0] wd; logic [BW-1:0] be; int hold;
    do_reset();
    r1_address = 12'h090; r1_read = 1;
    serve(3 * TO, 32'h31415926, a, rd, wr, wd, be, hold);
    tests_run++;
    if ({hold, r1_acknowledge, r1_read_data, timeout_err} !== {3 * TO, 1'b1, 32'h31415926, 2'b00}) begin
      tests_failed++;
      $display("FAIL no_timeout: hold=%0d ack=%b data=%h err=%b, required %0d 1 31415926 00",
               hold, r1_acknowledge, r1_read_data, timeout_err, 3 * TO);
    end
    r1_read = 0;
    tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_tie_writes();
    test_fairness();
    test_read_write_r1();
    test_reset_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ext_master_arbiter.md
Name: ext_master_arbiter

Overview:
- Shares one FPGA-to-HPS external bus master port (12-bit address, 32-bit data, acknowledge handshake) between two FPGA-side requesters.
- Each requester sees an identical external-bus-style interface.
- Arbitration is round-robin; a granted transaction is held on the master port until acknowledge.
- Sits between user logic and one external_master bridge conduit of Computer_System.

Parameters:
ADDR_W, 12, address width on all ports
DATA_W, 32, data width; byte enable width is DATA_W/8
TIMEOUT_CYCLES, 1024, master-side cycles to wait for acknowledge before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
r0_address  in  ADDR_W  requester 0 address
r0_byte_enable  in  DATA_W/8  requester 0 byte enables
r0_read  in  1  requester 0 read request, level, held until r0_acknowledge
r0_write  in  1  requester 0 write request, level, held until r0_acknowledge
r0_write_data  in  DATA_W  requester 0 write data
r0_acknowledge  out  1  one-cycle completion pulse to requester 0
r0_read_data  out  DATA_W  read data, valid while r0_acknowledge=1
r1_*  same 7 signals as r0_*, for requester 1
m_address  out  ADDR_W  to bridge address
m_byte_enable  out  DATA_W/8  to bridge byte_enable
m_read  out  1  to bridge read
m_write  out  1  to bridge write
m_write_data  out  DATA_W  to bridge write_data
m_acknowledge  in  1  from bridge acknowledge, one-cycle pulse
m_read_data  in  DATA_W  from bridge read_data, valid with m_acknowledge
timeout_err  out  2  sticky per-requester timeout flags

Behaviour:
- All outputs are registered. Reset (async, takes effect immediately) forces every output to 0, state to IDLE, and last_grant to 1, so requester 0 wins the first tie.
- Request: rN_req = rN_read | rN_write. If both rN_read and rN_write are high, the transaction is a write; the read is ignored.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - One request: grant it.
    - Both request: grant the requester != last_grant.
    - On grant: latch that requester's address, byte_enable, write_data and op into the m_* registers; assert m_read or m_write; record the grant; go to BUSY.
  - BUSY:
    - m_* outputs are held constant.
    - On m_acknowledge=1: drop m_read/m_write in the next cycle. Register m_read_data into rN_read_data (writes: rN_read_data=0). Pulse rN_acknowledge for exactly one cycle. Set last_grant=N. Go to DONE.
  - DONE: one cycle with rN_acknowledge high; then go to IDLE. This gives the requester one cycle to deassert its strobe before re-arbitration.
- Timing: request seen in IDLE at cycle T → m_read/m_write high at T+1. m_acknowledge at cycle A → rN_acknowledge high at A+1 → earliest next grant evaluated at A+2, master strobe at A+3.
- Requester inputs are ignored while not in IDLE. A requester dropping its strobe mid-transaction does not abort it; the ack pulse is still issued.
- m_acknowledge received in IDLE or DONE is ignored.
- The non-granted requester's acknowledge stays 0 and its read_data holds its previous value.
- Reset mid-transaction drops m_read/m_write immediately. The bridge transaction is abandoned, and no ack is issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle without m_acknowledge.
  - When it reaches TIMEOUT_CYCLES: drop the m_* strobes, pulse rN_acknowledge with rN_read_data=32'hDEADBEEF, set timeout_err[N] (sticky until reset), and go to DONE.
  - An ack arriving on the same cycle as expiry wins: normal completion, no error.
- Undefined: BUSY waits indefinitely; timeout_err is tied to 0; no counter logic.

Test Plan:
- Single read: r0_read=1, addr 12'h010; bridge acks 3 cycles after m_read with data 32'h12345678 → m_address=12'h010, m_read high for 3 cycles; r0_acknowledge one cycle with r0_read_data=32'h12345678; r1 signals stay 0.
- Tie after reset: r0_write and r1_write asserted the same cycle (held) → r0 served first, then r1; m_write_data follows each requester's data.
- Fairness: both requesters hold continuous reads for 4 transactions → grant order 0,1,0,1; no consecutive double grant.
- Read+write both high on r1, byte_enable 4'b0011 → m_write=1, m_read=0, m_byte_enable=4'b0011, r1_read_data=0 on ack.
- Reset asserted while BUSY → m_read/m_write go 0 without a clock edge; after release, no stray ack; next request is served with r0 winning the tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bridge never acks r1 read → r1_acknowledge pulses with 32'hDEADBEEF; timeout_err=2'b10, persisting through later successful transactions.
